// File: rtl/dot_arb_pkg.sv
// Shared types and helpers for the dot-product arbiter slice.
//   issue_state_t : issue FSM states (ARB, ISSUE)
//   q_t           : signed 32-bit Q-format word
//   vec3_t        : three-element vector of q_t
//   rr_next       : round-robin successor of a pointer over n slots
package dot_arb_pkg;

  localparam int unsigned DATA_W = 32;

  typedef enum logic {ARB, ISSUE} issue_state_t;

  typedef logic signed [DATA_W-1:0] q_t;
  typedef q_t [2:0] vec3_t;

  function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned n);
    return (ptr >= n - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/dot_arb_tag_fifo.sv
// Tag FIFO holding the requester index of every operation in flight.
//   clock, reset : clock, asynchronous active-high reset
//   push/push_tag: enqueue one tag (ignored while full)
//   pop          : dequeue the head tag (ignored while empty)
//   head         : show-ahead head tag
//   full, empty  : status derived from the registered count
//   count        : number of stored tags, 0..DEPTH
module dot_arb_tag_fifo #(
  parameter int unsigned TAG_W = 2,
  parameter int unsigned DEPTH = 8,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [TAG_W-1:0] push_tag,
  input  logic             pop,
  output logic [TAG_W-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [TAG_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_q;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign head    = mem[rd_ptr];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clock) begin
    if (do_push) begin
      mem[wr_ptr] <= push_tag;
    end
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/dot_arbiter.sv
// Shares one FIFO-interfaced 3-element dot-product unit among N_REQ requesters.
// Round-robin issue from the requesters' input FIFOs; the requester index of
// each issued operation is queued in a tag FIFO and used to route the in-order
// results back.
//   clock, reset        : clock, asynchronous active-high reset
//   req_x/req_y         : per-requester operand vectors (FIFO heads)
//   req_empty/req_rd_en : per-requester input FIFO status / pop (one-hot)
//   dot_x/dot_y         : operand presented to the dot unit
//   dot_empty/dot_rd_en : operand-available handshake toward the dot unit
//   dot_out/...         : dot unit result FIFO head, empty, pop
//   res_out             : result data shared by all requesters
//   res_full/res_wr_en  : per-requester result FIFO full / write (one-hot)
//   outstanding         : operations issued but not yet returned
//   busy                : work in flight or an issue pending
module dot_arbiter
  import dot_arb_pkg::*;
#(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned MAX_OUT = 8,
  localparam int unsigned TAG_W  = $clog2(N_REQ)
) (
  input  logic                       clock,
  input  logic                       reset,
  input  vec3_t [N_REQ-1:0]          req_x,
  input  vec3_t [N_REQ-1:0]          req_y,
  input  logic  [N_REQ-1:0]          req_empty,
  output logic  [N_REQ-1:0]          req_rd_en,
  output vec3_t                      dot_x,
  output vec3_t                      dot_y,
  output logic                       dot_empty,
  input  logic                       dot_rd_en,
  input  q_t                         dot_out,
  input  logic                       dot_out_empty,
  output logic                       dot_out_rd_en,
  output q_t                         res_out,
  input  logic  [N_REQ-1:0]          res_full,
  output logic  [N_REQ-1:0]          res_wr_en,
  output logic  [$clog2(MAX_OUT):0]  outstanding,
  output logic                       busy
);

  localparam int unsigned CNT_W = $clog2(MAX_OUT) + 1;

  issue_state_t     state_q, state_d;
  logic [TAG_W-1:0] grant_q, grant_d;
  logic [TAG_W-1:0] rr_ptr, rr_d;

  logic             any_elig;
  logic [TAG_W-1:0] pick;
  int unsigned      idx;

  logic             tag_push;
  logic             tag_pop;
  logic [TAG_W-1:0] tag_head;
  logic             tag_full;
  logic             tag_empty;
  logic [CNT_W-1:0] tag_count;
  logic             ret_go;

  // Search from rr_ptr, wrapping explicitly so N_REQ need not be a power of 2.
  always_comb begin
    any_elig = 1'b0;
    pick     = '0;
    idx      = 0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      idx = 32'(rr_ptr) + k;
      if (idx >= N_REQ) begin
        idx = idx - N_REQ;
      end
      if (!any_elig && !req_empty[TAG_W'(idx)]) begin
        any_elig = 1'b1;
        pick     = TAG_W'(idx);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    rr_d      = rr_ptr;
    dot_empty = 1'b1;
    req_rd_en = '0;
    tag_push  = 1'b0;
    case (state_q)
      ARB: begin
        if (any_elig && !tag_full) begin
          grant_d = pick;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        dot_empty = 1'b0;
        if (dot_rd_en) begin
          req_rd_en = N_REQ'(1) << grant_q;
          tag_push  = 1'b1;
          rr_d      = TAG_W'(rr_next(32'(grant_q), N_REQ));
          state_d   = ARB;
        end
      end
      default: state_d = ARB;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ARB;
      grant_q <= '0;
      rr_ptr  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_ptr  <= rr_d;
    end
  end

  assign dot_x = req_x[grant_q];
  assign dot_y = req_y[grant_q];

  // Return path: strictly in order, so a full head requester blocks everyone.
  assign ret_go        = !dot_out_empty && !tag_empty && !res_full[tag_head];
  assign tag_pop       = ret_go;
  assign dot_out_rd_en = ret_go;
  assign res_wr_en     = ret_go ? (N_REQ'(1) << tag_head) : '0;
  assign res_out       = dot_out;

  dot_arb_tag_fifo #(
    .TAG_W (TAG_W),
    .DEPTH (MAX_OUT)
  ) u_tag_fifo (
    .clock    (clock),
    .reset    (reset),
    .push     (tag_push),
    .push_tag (grant_q),
    .pop      (tag_pop),
    .head     (tag_head),
    .full     (tag_full),
    .empty    (tag_empty),
    .count    (tag_count)
  );

  assign outstanding = tag_count;
  assign busy        = (tag_count != '0) || (state_q == ISSUE);

  // A result with no matching tag means the dot unit produced an unrequested result.
  a_no_orphan_result: assert property (@(posedge clock) disable iff (reset)
    !(!dot_out_empty && tag_empty));

  a_outstanding_bound: assert property (@(posedge clock) disable iff (reset)
    tag_count <= CNT_W'(MAX_OUT));

endmodule

// File: tb/tb_dot_arbiter.sv
module tb_dot_arbiter;
  import dot_arb_pkg::*;

  localparam int unsigned N      = 4;
  localparam int unsigned MO     = 8;
  localparam int unsigned Q_BITS = 10;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  vec3_t [N-1:0]     req_x;
  vec3_t [N-1:0]     req_y;
  logic  [N-1:0]     req_empty;
  logic  [N-1:0]     req_rd_en;
  vec3_t             dot_x;
  vec3_t             dot_y;
  logic              dot_empty;
  logic              dot_rd_en;
  q_t                dot_out;
  logic              dot_out_empty;
  logic              dot_out_rd_en;
  q_t                res_out;
  logic  [N-1:0]     res_full;
  logic  [N-1:0]     res_wr_en;
  logic  [3:0]       outstanding;
  logic              busy;

  dot_arbiter #(.N_REQ(N), .MAX_OUT(MO)) dut (
    .clock         (clock),
    .reset         (reset),
    .req_x         (req_x),
    .req_y         (req_y),
    .req_empty     (req_empty),
    .req_rd_en     (req_rd_en),
    .dot_x         (dot_x),
    .dot_y         (dot_y),
    .dot_empty     (dot_empty),
    .dot_rd_en     (dot_rd_en),
    .dot_out       (dot_out),
    .dot_out_empty (dot_out_empty),
    .dot_out_rd_en (dot_out_rd_en),
    .res_out       (res_out),
    .res_full      (res_full),
    .res_wr_en     (res_wr_en),
    .outstanding   (outstanding),
    .busy          (busy)
  );

  always #5 clock = ~clock;

  // Environment models: requester FIFOs, dot unit with result FIFO, result sinks.
  vec3_t    qx [N][$];
  vec3_t    qy [N][$];
  q_t       dot_q [$];
  int       budget;
  logic [N-1:0] res_full_v;

  int       grant_log [$];
  int       wr_log [$];
  q_t       res_log [N][$];
  int       issued, total_wr, wr_cnt, pop_cnt;

  logic [N-1:0] s_rd, s_wr;
  logic     s_pop, s_acc, s_dempty, s_busy;
  q_t       s_res;
  vec3_t    s_dx, s_dy;

  int       checks = 0;
  int       errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic vec3_t mk(input int a, input int b, input int c);
    vec3_t v;
    v[0] = q_t'(a);
    v[1] = q_t'(b);
    v[2] = q_t'(c);
    return v;
  endfunction

  function automatic q_t dot_fn(input vec3_t a, input vec3_t b);
    longint acc = 0;
    for (int k = 0; k < 3; k++) begin
      acc += longint'(a[k]) * longint'(b[k]);
    end
    return q_t'(acc >>> Q_BITS);
  endfunction

  task automatic push_op(input int r, input vec3_t x, input vec3_t y);
    qx[r].push_back(x);
    qy[r].push_back(y);
  endtask

  task automatic clear_logs();
    grant_log.delete();
    wr_log.delete();
    for (int i = 0; i < N; i++) res_log[i].delete();
    issued = 0; total_wr = 0; wr_cnt = 0; pop_cnt = 0;
  endtask

  task automatic cycle();
    @(negedge clock);
    for (int i = 0; i < N; i++) begin
      req_empty[i] = (qx[i].size() == 0);
      req_x[i]     = (qx[i].size() != 0) ? qx[i][0] : '0;
      req_y[i]     = (qy[i].size() != 0) ? qy[i][0] : '0;
    end
    dot_out_empty = (dot_q.size() == 0) || (budget == 0);
    dot_out       = (dot_q.size() != 0) ? dot_q[0] : '0;
    res_full      = res_full_v;
    #1;
    dot_rd_en = !dot_empty;
    #1;
    s_rd     = req_rd_en;
    s_wr     = res_wr_en;
    s_pop    = dot_out_rd_en;
    s_res    = res_out;
    s_acc    = dot_rd_en && !dot_empty;
    s_dx     = dot_x;
    s_dy     = dot_y;
    s_dempty = dot_empty;
    s_busy   = busy;
    @(posedge clock);
    if (s_pop && dot_q.size() != 0) begin
      void'(dot_q.pop_front());
      if (budget > 0) budget--;
      pop_cnt++;
    end
    if (s_acc) begin
      dot_q.push_back(dot_fn(s_dx, s_dy));
      issued++;
    end
    for (int i = 0; i < N; i++) begin
      if (s_rd[i] && qx[i].size() != 0) begin
        void'(qx[i].pop_front());
        void'(qy[i].pop_front());
        grant_log.push_back(i);
      end
      if (s_wr[i]) begin
        res_log[i].push_back(s_res);
        wr_log.push_back(i);
        total_wr++;
      end
    end
    if (s_wr != '0) wr_cnt++;
    #1;
  endtask

  task automatic cycles(input int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  task automatic run_until_wr(input int n, input int limit, input string tag);
    int c = 0;
    while (total_wr < n && c < limit) begin
      cycle();
      c++;
    end
    check(tag, 64'(total_wr), 64'(n));
  endtask

  task automatic reset_on();
    @(negedge clock);
    reset         = 1'b1;
    dot_rd_en     = 1'b0;
    dot_out_empty = 1'b1;
    res_full_v    = '0;
    res_full      = '0;
    dot_q.delete();
    clear_logs();
    #2;
  endtask

  task automatic reset_off();
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    req_x = '0; req_y = '0; req_empty = '1; dot_rd_en = 1'b0;
    dot_out = '0; dot_out_empty = 1'b1; res_full = '0; res_full_v = '0;
    budget = 1000;
    clear_logs();

    // Reset state
    reset_on();
    check("rst_req_rd_en", 64'(req_rd_en), 64'(0));
    check("rst_dot_out_rd_en", 64'(dot_out_rd_en), 64'(0));
    check("rst_res_wr_en", 64'(res_wr_en), 64'(0));
    check("rst_dot_empty", 64'(dot_empty), 64'(1));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_outstanding", 64'(outstanding), 64'(0));
    reset_off();

    // Single op on requester 2
    push_op(2, mk(1024, 2048, 0), mk(1024, 1024, 0));
    run_until_wr(1, 20, "single_done");
    check("single_grant", 64'(grant_log.size() > 0 ? grant_log[0] : -1), 64'(2));
    check("single_wr_en", 64'(s_wr), 64'(4'b0100));
    check("single_res", 64'(s_res), 64'(3072));
    check("single_outstanding", 64'(outstanding), 64'(0));

    // Round robin, all requesters busy, no back-pressure
    reset_on(); reset_off();
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < N; i++)
        push_op(i, mk(1024 * (i + 1), 1024 * k, -1024), mk(1024, 2048, 1024));
    run_until_wr(12, 200, "rr_done");
    check("rr_grants", 64'(grant_log.size()), 64'(12));
    for (int k = 0; k < 12; k++)
      check("rr_order", 64'(k < grant_log.size() ? grant_log[k] : -1), 64'(k % 4));
    for (int i = 0; i < N; i++)
      for (int k = 0; k < 3; k++)
        check("rr_result", 64'(k < res_log[i].size() ? res_log[i][k] : q_t'(-1)),
              64'(q_t'(1024 * i + 2048 * k)));

    // Outstanding limit
    reset_on(); reset_off();
    budget = 0;
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < N; i++)
        push_op(i, mk(1024 * (i + 1), 1024 * k, -1024), mk(1024, 2048, 1024));
    cycles(40);
    check("lim_issued", 64'(issued), 64'(8));
    check("lim_outstanding", 64'(outstanding), 64'(8));
    check("lim_parked_dot_empty", 64'(s_dempty), 64'(1));
    check("lim_busy", 64'(s_busy), 64'(1));
    budget = 1;
    cycles(10);
    check("lim_one_more_issue", 64'(issued), 64'(9));
    check("lim_outstanding_again", 64'(outstanding), 64'(8));
    check("lim_one_return", 64'(total_wr), 64'(1));
    budget = 1000;
    run_until_wr(12, 150, "lim_drain");
    check("lim_drained", 64'(outstanding), 64'(0));

    // Head-of-line blocking with tags [1,3]
    reset_on(); reset_off();
    res_full_v = 4'b0010;
    push_op(1, mk(2048, 0, 0), mk(1024, 0, 0));
    push_op(3, mk(-3072, 0, 0), mk(1024, 0, 0));
    for (int c = 0; c < 20 && !(issued == 2 && dot_q.size() == 2); c++) cycle();
    check("hol_outstanding", 64'(outstanding), 64'(2));
    wr_cnt = 0; pop_cnt = 0;
    cycles(5);
    check("hol_no_write", 64'(wr_cnt), 64'(0));
    check("hol_no_pop", 64'(pop_cnt), 64'(0));
    check("hol_results_wait", 64'(dot_q.size()), 64'(2));
    res_full_v = '0;
    cycle();
    check("hol_first_wr", 64'(s_wr), 64'(4'b0010));
    check("hol_first_res", 64'(s_res), 64'(2048));
    cycle();
    check("hol_second_wr", 64'(s_wr), 64'(4'b1000));
    check("hol_second_res", 64'(s_res), 64'(-3072));

    // Simultaneous push and pop at outstanding = 4
    reset_on(); reset_off();
    budget = 0;
    for (int i = 0; i < N; i++) push_op(i, mk(1024 * (i + 1), 0, 0), mk(1024, 0, 0));
    cycles(10);
    check("sim_outstanding_pre", 64'(outstanding), 64'(4));
    push_op(2, mk(5120, 0, 0), mk(1024, 0, 0));
    cycle();
    budget = 1;
    cycle();
    check("sim_issue", 64'(s_rd), 64'(4'b0100));
    check("sim_return", 64'(s_wr), 64'(4'b0001));
    check("sim_outstanding_post", 64'(outstanding), 64'(4));
    budget = 1000;
    run_until_wr(5, 40, "sim_drain");
    for (int k = 0; k < 5; k++) begin
      int exp_r;
      exp_r = (k == 4) ? 2 : k;
      check("sim_wr_order", 64'(k < wr_log.size() ? wr_log[k] : -1), 64'(exp_r));
    end
    check("sim_r2_second", 64'(res_log[2].size() > 1 ? res_log[2][1] : q_t'(-1)), 64'(5120));

    // Reset mid-flight
    reset_on(); reset_off();
    budget = 0;
    for (int i = 0; i < 3; i++) push_op(i, mk(1024, 0, 0), mk(1024, 0, 0));
    cycles(6);
    check("mid_outstanding_pre", 64'(outstanding), 64'(3));
    push_op(3, mk(1024, 0, 0), mk(1024, 0, 0));
    push_op(2, mk(1024, 0, 0), mk(1024, 0, 0));
    reset_on();
    check("mid_outstanding", 64'(outstanding), 64'(0));
    check("mid_req_rd_en", 64'(req_rd_en), 64'(0));
    check("mid_dot_out_rd_en", 64'(dot_out_rd_en), 64'(0));
    check("mid_res_wr_en", 64'(res_wr_en), 64'(0));
    check("mid_dot_empty", 64'(dot_empty), 64'(1));
    check("mid_busy", 64'(busy), 64'(0));
    reset_off();
    budget = 1000;
    for (int c = 0; c < 10 && grant_log.size() == 0; c++) cycle();
    check("mid_first_grant", 64'(grant_log.size() > 0 ? grant_log[0] : -1), 64'(2));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
